parking_gate_ctrl: RTL and testbench

//  Gate/occupancy controller that drives the door_open and full_parking events consumed by the LED blinker.
//  - Takes entry/exit/car-pass sensors and runs a single shared barrier through an FSM.
//  - Tracks occupancy against CAPACITY.
//  - Emits 1-cycle event pulses: the blinker restarts on a held level, so events must be pulses, never levels.

---
 rtl/parking_gate_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// rtl/parking_gate_ctrl.sv - single-barrier parking gate FSM with occupancy tracking (option: PARKING_DEBOUNCE_EN)
module parking_gate_ctrl #(
    parameter int CLK_FREQ        = 40_000_000,
    parameter int CAPACITY        = 16,
    parameter int CNT_W           = 5,
    parameter int PASS_TIMEOUT    = 10 * CLK_FREQ,
    parameter int DEBOUNCE_CYCLES = CLK_FREQ / 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             car_pass,
    output logic             door_open,
    output logic             full_parking,
    output logic             gate_open,
    output logic [CNT_W-1:0] occupancy,
    output logic             is_full,
    output logic             pass_timeout
);

    localparam int TMR_W = (PASS_TIMEOUT > 1) ? $clog2(PASS_TIMEOUT) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PASS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CAP_V    = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] CAP_M1   = CNT_W'(CAPACITY - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_OPEN_IN   = 3'd1;
    localparam logic [2:0] S_OPEN_OUT  = 3'd2;
    localparam logic [2:0] S_GUARD_IN  = 3'd3;
    localparam logic [2:0] S_GUARD_OUT = 3'd4;

    // Sensor bit order: [0] entry, [1] exit, [2] car_pass
    logic [2:0]       raw;
    logic [2:0]       sync_q1;
    logic [2:0]       sync_q2;
    logic [2:0]       clean;
    logic             entry_s;
    logic             exit_s;
    logic             pass_s;
    logic             pass_q;
    logic             pass_edge;
    logic             rej;
    logic [2:0]       state;
    logic [TMR_W-1:0] timer;

    assign raw = {car_pass, exit_req, entry_req};

    // Two-flop synchroniser for the asynchronous sensor levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

`ifdef PARKING_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]      deb;
    logic [DB_W-1:0] db_cnt [3];

    // Output follows a sensor only after it has disagreed for DEBOUNCE_CYCLES straight samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_q2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync_q2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign clean = deb;
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = (DEBOUNCE_CYCLES > 0);
    assign clean = sync_q2;
`endif

    assign entry_s   = clean[0];
    assign exit_s    = clean[1];
    assign pass_s    = clean[2];
    assign pass_edge = pass_s & ~pass_q;

    // Barrier FSM; outputs are registered so pulses are exactly one cycle wide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            timer        <= '0;
            pass_q       <= 1'b0;
            rej          <= 1'b0;
            door_open    <= 1'b0;
            full_parking <= 1'b0;
            pass_timeout <= 1'b0;
            gate_open    <= 1'b0;
            occupancy    <= '0;
            is_full      <= 1'b0;
        end else begin
            pass_q       <= pass_s;
            door_open    <= 1'b0;
            full_parking <= 1'b0;
            pass_timeout <= 1'b0;
            if (!entry_s) rej <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (exit_s && occupancy != '0) begin
                        state     <= S_OPEN_OUT;
                        timer     <= '0;
                        door_open <= 1'b1;
                        gate_open <= 1'b1;
                    end else if (entry_s && !is_full) begin
                        state     <= S_OPEN_IN;
                        timer     <= '0;
                        door_open <= 1'b1;
                        gate_open <= 1'b1;
                    end else if (entry_s && is_full && !rej) begin
                        full_parking <= 1'b1;
                        rej          <= 1'b1;
                    end
                end
                S_OPEN_IN: begin
                    if (pass_edge) begin
                        if (occupancy < CAP_V) begin
                            occupancy <= occupancy + 1'b1;
                            is_full   <= (occupancy == CAP_M1);
                        end
                        state     <= S_GUARD_IN;
                        gate_open <= 1'b0;
                    end else if (timer == TMR_LAST) begin
                        pass_timeout <= 1'b1;
                        state        <= S_GUARD_IN;
                        gate_open    <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_OPEN_OUT: begin
                    if (pass_edge) begin
                        if (occupancy != '0) begin
                            occupancy <= occupancy - 1'b1;
                            is_full   <= 1'b0;
                        end
                        state     <= S_GUARD_OUT;
                        gate_open <= 1'b0;
                    end else if (timer == TMR_LAST) begin
                        pass_timeout <= 1'b1;
                        state        <= S_GUARD_OUT;
                        gate_open    <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_GUARD_IN: begin
                    if (!entry_s) state <= S_IDLE;
                end
                S_GUARD_OUT: begin
                    if (!exit_s) state <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    gate_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb/tb_parking_gate_ctrl.sv - directed self-checking bench for parking_gate_ctrl
module tb_parking_gate_ctrl;

`ifdef PARKING_DEBOUNCE_EN
    localparam int EXTRA = 8;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk;
    logic       reset;
    logic       entry_req;
    logic       exit_req;
    logic       car_pass;
    logic       door_open;
    logic       full_parking;
    logic       gate_open;
    logic [1:0] occupancy;
    logic       is_full;
    logic       pass_timeout;

    int checks;
    int passed;
    int n_door;
    int n_full;
    int n_to;
    int n_overlap;

    parking_gate_ctrl #(
        .CLK_FREQ       (8000),
        .CAPACITY       (2),
        .CNT_W          (2),
        .PASS_TIMEOUT   (20),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .entry_req   (entry_req),
        .exit_req    (exit_req),
        .car_pass    (car_pass),
        .door_open   (door_open),
        .full_parking(full_parking),
        .gate_open   (gate_open),
        .occupancy   (occupancy),
        .is_full     (is_full),
        .pass_timeout(pass_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            n_door = n_door + int'(door_open);
            n_full = n_full + int'(full_parking);
            n_to   = n_to + int'(pass_timeout);
            if (int'(door_open) + int'(full_parking) + int'(pass_timeout) > 1) n_overlap = n_overlap + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic car_through();
        car_pass = 1'b1;
        repeat (3 + EXTRA) tick();
        car_pass = 1'b0;
        repeat (2 + EXTRA) tick();
    endtask

    task automatic wait_gate();
        for (int i = 0; i < 40 && gate_open !== 1'b1; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (gate_open !== 1'b0) $display("FAIL reset_gate_open: got %b expected 0", gate_open); else passed++;
        checks++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d expected 0", occupancy); else passed++;
        checks++; if ({door_open, full_parking, pass_timeout, is_full} !== 4'b0) $display("FAIL reset_pulses: got %b expected 0000", {door_open, full_parking, pass_timeout, is_full}); else passed++;
        reset = 1'b0;
        repeat (2) tick();
        checks++; if (gate_open !== 1'b0) $display("FAIL idle_gate_open: got %b expected 0", gate_open); else passed++;
    endtask

    task automatic test_entry();
        entry_req = 1'b1;
        repeat (2 + EXTRA) tick();
        checks++; if (door_open !== 1'b0) $display("FAIL entry_early_door: got %b expected 0", door_open); else passed++;
        tick();
        checks++; if ({door_open, gate_open} !== 2'b11) $display("FAIL entry_door_gate: got %b expected 11", {door_open, gate_open}); else passed++;
        tick();
        checks++; if ({door_open, gate_open} !== 2'b01) $display("FAIL entry_pulse_width: got %b expected 01", {door_open, gate_open}); else passed++;
        car_pass = 1'b1;
        repeat (3 + EXTRA) tick();
        checks++; if (occupancy !== 2'd1) $display("FAIL entry_occupancy: got %0d expected 1", occupancy); else passed++;
        checks++; if (gate_open !== 1'b0) $display("FAIL entry_gate_closed: got %b expected 0", gate_open); else passed++;
        car_pass = 1'b0;
        repeat (2 + EXTRA) tick();
        entry_req = 1'b0;
        repeat (4 + EXTRA) tick();
        checks++; if (n_door !== 1) $display("FAIL entry_door_count: got %0d expected 1", n_door); else passed++;
    endtask

    task automatic test_full();
        int  d0;
        int  f0;
        logic gate_seen;
        entry_req = 1'b1;
        wait_gate();
        car_through();
        checks++; if ({is_full, occupancy} !== 3'b110) $display("FAIL full_reached: got full=%b occ=%0d expected full=1 occ=2", is_full, occupancy); else passed++;
        entry_req = 1'b0;
        repeat (4 + EXTRA) tick();
        d0 = n_door;
        f0 = n_full;
        gate_seen = 1'b0;
        entry_req = 1'b1;
        repeat (50) begin
            tick();
            if (gate_open === 1'b1) gate_seen = 1'b1;
        end
        checks++; if (n_full !== f0 + 1) $display("FAIL full_pulse_count: got %0d expected %0d", n_full, f0 + 1); else passed++;
        checks++; if (gate_seen !== 1'b0 || n_door !== d0) $display("FAIL full_gate_stayed_shut: got gate_seen=%b doors=%0d expected 0/%0d", gate_seen, n_door, d0); else passed++;
        exit_req = 1'b1;
        wait_gate();
        tick();
        checks++; if (n_door !== d0 + 1) $display("FAIL full_exit_open: got %0d expected %0d", n_door, d0 + 1); else passed++;
        car_through();
        checks++; if ({is_full, occupancy} !== 3'b001) $display("FAIL full_exit_occ: got full=%b occ=%0d expected full=0 occ=1", is_full, occupancy); else passed++;
        exit_req = 1'b0;
        for (int i = 0; i < 40 && n_door < d0 + 2; i++) tick();
        checks++; if (n_door !== d0 + 2 || gate_open !== 1'b1) $display("FAIL full_held_entry_serviced: got doors=%0d gate=%b expected %0d/1", n_door, gate_open, d0 + 2); else passed++;
        car_through();
        entry_req = 1'b0;
        repeat (4 + EXTRA) tick();
        exit_req = 1'b1;
        wait_gate();
        car_through();
        exit_req = 1'b0;
        repeat (4 + EXTRA) tick();
        checks++; if (occupancy !== 2'd1) $display("FAIL full_back_to_one: got %0d expected 1", occupancy); else passed++;
    endtask

    task automatic test_timeout();
        int n;
        int t0;
        t0 = n_to;
        entry_req = 1'b1;
        wait_gate();
        n = 0;
        while (gate_open === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        checks++; if (n !== 20) $display("FAIL timeout_open_cycles: got %0d expected 20", n); else passed++;
        checks++; if (pass_timeout !== 1'b1) $display("FAIL timeout_pulse: got %b expected 1", pass_timeout); else passed++;
        tick();
        checks++; if (n_to !== t0 + 1 || occupancy !== 2'd1) $display("FAIL timeout_count_occ: got to=%0d occ=%0d expected %0d/1", n_to, occupancy, t0 + 1); else passed++;
        entry_req = 1'b0;
        repeat (4 + EXTRA) tick();
    endtask

    task automatic test_exit_priority();
        int d0;
        d0 = n_door;
        entry_req = 1'b1;
        exit_req  = 1'b1;
        repeat (3 + EXTRA) tick();
        checks++; if (gate_open !== 1'b1) $display("FAIL prio_gate_open: got %b expected 1", gate_open); else passed++;
        car_through();
        checks++; if (occupancy !== 2'd0) $display("FAIL prio_exit_first: got %0d expected 0", occupancy); else passed++;
        exit_req = 1'b0;
        for (int i = 0; i < 40 && n_door < d0 + 2; i++) tick();
        checks++; if (n_door !== d0 + 2) $display("FAIL prio_entry_next: got %0d expected %0d", n_door, d0 + 2); else passed++;
        car_through();
        checks++; if (occupancy !== 2'd1) $display("FAIL prio_entry_occ: got %0d expected 1", occupancy); else passed++;
        entry_req = 1'b0;
        repeat (4 + EXTRA) tick();
    endtask

    task automatic test_reset_mid_open();
        entry_req = 1'b1;
        wait_gate();
        checks++; if (gate_open !== 1'b1 || occupancy !== 2'd1) $display("FAIL midrst_setup: got gate=%b occ=%0d expected 1/1", gate_open, occupancy); else passed++;
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({gate_open, occupancy} !== 3'b000) $display("FAIL midrst_async: got gate=%b occ=%0d expected 0/0", gate_open, occupancy); else passed++;
        checks++; if ({door_open, full_parking, pass_timeout, is_full} !== 4'b0) $display("FAIL midrst_pulses: got %b expected 0000", {door_open, full_parking, pass_timeout, is_full}); else passed++;
        entry_req = 1'b0;
        reset = 1'b0;
        repeat (4 + EXTRA) tick();
        checks++; if (gate_open !== 1'b0) $display("FAIL midrst_idle: got %b expected 0", gate_open); else passed++;
    endtask

    task automatic test_exit_empty();
        int d0;
        d0 = n_door;
        exit_req = 1'b1;
        repeat (10 + EXTRA) tick();
        checks++; if (n_door !== d0 || gate_open !== 1'b0 || occupancy !== 2'd0) $display("FAIL empty_exit_ignored: got doors=%0d gate=%b occ=%0d expected %0d/0/0", n_door, gate_open, occupancy, d0); else passed++;
        exit_req = 1'b0;
        repeat (4 + EXTRA) tick();
    endtask

`ifdef PARKING_DEBOUNCE_EN
    task automatic test_debounce();
        int d0;
        d0 = n_door;
        entry_req = 1'b1;
        repeat (5) tick();
        entry_req = 1'b0;
        repeat (20) tick();
        checks++; if (n_door !== d0) $display("FAIL deb_glitch: got %0d expected %0d", n_door, d0); else passed++;
        entry_req = 1'b1;
        repeat (10) tick();
        checks++; if (door_open !== 1'b0) $display("FAIL deb_early: got %b expected 0", door_open); else passed++;
        tick();
        checks++; if (door_open !== 1'b1) $display("FAIL deb_latency: got %b expected 1", door_open); else passed++;
        tick();
        entry_req = 1'b0;
        repeat (40) tick();
    endtask
`endif

    initial begin
        checks    = 0;
        passed    = 0;
        n_door    = 0;
        n_full    = 0;
        n_to      = 0;
        n_overlap = 0;
        reset     = 1'b1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        car_pass  = 1'b0;
        test_reset();
        test_entry();
        test_full();
        test_timeout();
        test_exit_priority();
        test_reset_mid_open();
        test_exit_empty();
`ifdef PARKING_DEBOUNCE_EN
        test_debounce();
`endif
        checks++; if (n_overlap !== 0) $display("FAIL pulse_exclusive: got %0d overlaps expected 0", n_overlap); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
